crc8_stream_checker: RTL and testbench

CRC8_STREAM_CHECKER -- requirements
Module: crc8_stream_checker

---
 rtl/crc8_stream_checker.sv | 144 ++++++++++++++
 tb/tb_crc8_stream_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_stream_checker.sv
// Byte-serial CRC-8 checker: absorbs one byte per handshake, shifting it MSB-first
// through the CRC register one bit per cycle, and compares the signature on request.
module crc8_stream_checker #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [7:0] data,
  input  logic       new_data,
  input  logic       check,
  input  logic [7:0] expected_crc,
  output logic       busy,
  output logic [7:0] result_crc8,
  output logic [8:0] byte_count,
  output logic       done,
  output logic       match
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    RELEASE,
    COMPARE,
    HOLD
  } state_e;

  localparam logic [8:0] COUNT_MAX = 9'd511;

  state_e     state_q, state_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] shiftReg_q, shiftReg_d;
  logic [2:0] bitCount_q, bitCount_d;
  logic [8:0] byteCount_q, byteCount_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       match_q, match_d;

  function automatic logic [7:0] crcStep(input logic [7:0] crc, input logic inBit);
    logic fb;
    fb = crc[7] ^ inBit;
    return {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  endfunction

  // Next-state logic; clr is applied last so it overrides every state.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    shiftReg_d  = shiftReg_q;
    bitCount_d  = bitCount_q;
    byteCount_d = byteCount_q;
    busy_d      = busy_q;
    done_d      = done_q;
    match_d     = match_q;

    unique case (state_q)
      IDLE: begin
        if (new_data) begin
          busy_d     = 1'b1;
          shiftReg_d = data;
          bitCount_d = 3'd0;
          state_d    = SHIFT;
        end else if (check) begin
          busy_d  = 1'b1;
          state_d = COMPARE;
        end
      end
      SHIFT: begin
        crc_d      = crcStep(crc_q, shiftReg_q[7]);
        shiftReg_d = {shiftReg_q[6:0], 1'b0};
        bitCount_d = bitCount_q + 3'd1;
        if (bitCount_q == 3'd7) begin
          busy_d  = 1'b0;
          done_d  = 1'b0;
          state_d = RELEASE;
          if (byteCount_q != COUNT_MAX) begin
            byteCount_d = byteCount_q + 9'd1;
          end
        end
      end
      RELEASE: begin
        if (!new_data) begin
          state_d = IDLE;
        end
      end
      COMPARE: begin
        match_d = (crc_q == expected_crc);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = HOLD;
      end
      HOLD: begin
        if (!check) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (clr) begin
      state_d     = IDLE;
      crc_d       = INIT;
      shiftReg_d  = 8'h00;
      bitCount_d  = 3'd0;
      byteCount_d = 9'd0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      match_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      shiftReg_q  <= 8'h00;
      bitCount_q  <= 3'd0;
      byteCount_q <= 9'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      shiftReg_q  <= shiftReg_d;
      bitCount_q  <= bitCount_d;
      byteCount_q <= byteCount_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      match_q     <= match_d;
    end
  end

  assign busy        = busy_q;
  assign result_crc8 = crc_q;
  assign byte_count  = byteCount_q;
  assign done        = done_q;
  assign match       = match_q;

endmodule

// File: tb/tb_crc8_stream_checker.sv
// Scoreboard bench for crc8_stream_checker: stimulus pushes expected byte/compare results,
// a negedge monitor pops them whenever a busy period ends.
module tb_crc8_stream_checker;

  localparam logic [7:0] POLY = 8'h07;
  localparam logic [7:0] INIT = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [7:0] data;
  logic       new_data;
  logic       check;
  logic [7:0] expected_crc;
  logic       busy;
  logic [7:0] result_crc8;
  logic [8:0] byte_count;
  logic       done;
  logic       match;

  crc8_stream_checker #(.POLY(POLY), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .clr(clr), .data(data), .new_data(new_data),
    .check(check), .expected_crc(expected_crc), .busy(busy),
    .result_crc8(result_crc8), .byte_count(byte_count), .done(done), .match(match)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         isCompare;
    logic [7:0] crc;
    int         count;
    bit         matchExp;
    int         cycles;
  } expT;

  expT        sbQ[$];
  expT        monExp;
  logic [7:0] modelCrc;
  int         modelCount;

  // Reference: remainder of (register ^ byte) * x^8 divided by the generator polynomial.
  function automatic logic [7:0] polyMod(input logic [15:0] v);
    logic [15:0] r;
    logic [15:0] gen;
    r   = v;
    gen = {7'd0, 1'b1, POLY};
    for (int i = 15; i >= 8; i--) begin
      if (r[i]) r = r ^ (gen << (i - 8));
    end
    return r[7:0];
  endfunction

  function automatic void modelClear();
    modelCrc   = INIT;
    modelCount = 0;
  endfunction

  function automatic void modelAbsorb(input logic [7:0] b);
    modelCrc = polyMod({modelCrc ^ b, 8'h00});
    if (modelCount < 511) modelCount++;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitBusyCycle(input string name);
    bit seen = 1'b0;
    bit finished = 1'b0;
    for (int i = 0; i < 40 && !finished; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) seen = 1'b1;
      else if (seen) finished = 1'b1;
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no completed busy period, expected one within 40 cycles", name);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    data     = b;
    new_data = 1'b1;
    modelAbsorb(b);
    sbQ.push_back('{1'b0, modelCrc, modelCount, 1'b0, 8});
    waitBusyCycle("byte handshake");
    new_data = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic issueCheck(input logic [7:0] exp);
    expected_crc = exp;
    check        = 1'b1;
    sbQ.push_back('{1'b1, modelCrc, modelCount, (modelCrc == exp), 1});
    waitBusyCycle("compare handshake");
    check = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic doClear();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    modelClear();
  endtask

  // Monitor: every end of a busy period is one scoreboard transaction.
  int busyRun  = 0;
  bit prevBusy = 1'b0;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      busyRun  = 0;
      prevBusy = 1'b0;
    end else begin
      if (busy === 1'b1) begin
        busyRun++;
      end else if (prevBusy) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb unexpected output: got busy period with crc %0h count %0d, expected none",
                   result_crc8, byte_count);
        end else begin
          monExp = sbQ.pop_front();
          checkOutput("sb done", 32'(done), 32'(monExp.isCompare));
          checkOutput("sb crc", 32'(result_crc8), 32'(monExp.crc));
          checkOutput("sb count", 32'(byte_count), 32'(monExp.count));
          checkOutput("sb busy cycles", 32'(busyRun), 32'(monExp.cycles));
          if (monExp.isCompare) checkOutput("sb match", 32'(match), 32'(monExp.matchExp));
        end
        busyRun = 0;
      end
      prevBusy = (busy === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 1000000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string      digits;
    logic [7:0] e;
    digits = "123456789";
    rst = 1'b0; clr = 1'b0; new_data = 1'b0; check = 1'b0;
    data = 8'h00; expected_crc = 8'h00;
    modelClear();

    #1;
    checkOutput("reset async busy", 32'(busy), 32'd0);
    checkOutput("reset async crc", 32'(result_crc8), 32'(INIT));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset crc", 32'(result_crc8), 32'h00);
    checkOutput("reset count", 32'(byte_count), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset match", 32'(match), 32'd0);

    applyStimulus(8'h01);
    checkOutput("crc of 01", 32'(result_crc8), 32'h07);
    checkOutput("count after 01", 32'(byte_count), 32'd1);

    doClear();
    checkOutput("count after clr", 32'(byte_count), 32'd0);
    applyStimulus(8'hFF);
    checkOutput("crc of FF", 32'(result_crc8), 32'hF3);

    doClear();
    for (int i = 0; i < digits.len(); i++) applyStimulus(digits[i]);
    checkOutput("crc of 123456789", 32'(result_crc8), 32'hF4);
    checkOutput("count of 123456789", 32'(byte_count), 32'd9);
    issueCheck(8'hF4);
    checkOutput("check F4 done", 32'(done), 32'd1);
    checkOutput("check F4 match", 32'(match), 32'd1);
    issueCheck(8'hF5);
    checkOutput("check F5 done", 32'(done), 32'd1);
    checkOutput("check F5 match", 32'(match), 32'd0);

    // Reset asserted while the fifth bit is pending.
    data = 8'hA5;
    new_data = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("busy before rst", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rst mid busy", 32'(busy), 32'd0);
    checkOutput("rst mid crc", 32'(result_crc8), 32'(INIT));
    checkOutput("rst mid count", 32'(byte_count), 32'd0);
    checkOutput("rst mid done", 32'(done), 32'd0);
    new_data = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    modelClear();
    @(posedge clk);
    #1;

    data = 8'h3C;
    new_data = 1'b1;
    modelAbsorb(8'h3C);
    sbQ.push_back('{1'b0, modelCrc, modelCount, 1'b0, 8});
    repeat (20) @(posedge clk);
    #1;
    new_data = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("held new_data count", 32'(byte_count), 32'd1);
    checkOutput("held new_data crc", 32'(result_crc8), 32'(modelCrc));

    // Clear asserted while the fifth bit is pending.
    applyStimulus(8'h5A);
    data = 8'hC3;
    new_data = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("busy before clr", 32'(busy), 32'd1);
    clr = 1'b1;
    sbQ.push_back('{1'b0, INIT, 0, 1'b0, 5});
    @(posedge clk);
    #1;
    checkOutput("clr mid busy", 32'(busy), 32'd0);
    checkOutput("clr mid crc", 32'(result_crc8), 32'h00);
    checkOutput("clr mid count", 32'(byte_count), 32'd0);
    clr = 1'b0;
    new_data = 1'b0;
    modelClear();
    @(posedge clk);
    #1;

    data = 8'h9E;
    modelAbsorb(8'h9E);
    sbQ.push_back('{1'b0, modelCrc, modelCount, 1'b0, 8});
    expected_crc = modelCrc;
    sbQ.push_back('{1'b1, modelCrc, modelCount, 1'b1, 1});
    new_data = 1'b1;
    check = 1'b1;
    waitBusyCycle("concurrent byte");
    new_data = 1'b0;
    waitBusyCycle("concurrent compare");
    check = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("concurrent done", 32'(done), 32'd1);
    checkOutput("concurrent match", 32'(match), 32'd1);

    doClear();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        e = ($urandom_range(0, 1) == 1) ? modelCrc : (modelCrc ^ (8'h01 << $urandom_range(0, 7)));
        issueCheck(e);
      end else begin
        applyStimulus(8'($urandom));
      end
    end

    doClear();
    repeat (512) applyStimulus(8'($urandom));
    checkOutput("saturated count", 32'(byte_count), 32'd511);
    checkOutput("long stream crc", 32'(result_crc8), 32'(modelCrc));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
